// File: rtl/pwm_audio_mc.sv
// pwm_audio_mc -- multi-channel PWM audio DAC back end.
//
// Accepts one packed sample word per frame (all channels) over a valid/ready
// handshake and holds it in a one-deep pending buffer. At each frame boundary
// the pending word becomes the active duty set. One registered PWM output is
// driven per channel. The period and the edge/centre mode are sampled at the
// frame boundary, so changes made mid-frame only take effect in the next frame.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   en         run enable; when low the counter parks at 0 and outputs go low
//   mode       0 = edge-aligned, 1 = centre-aligned (sampled at frame boundary)
//   period     frame period P (sampled at frame boundary)
//   s_valid    sample word valid
//   s_ready    high while the pending buffer is empty
//   s_data     channel i duty in bits [i*WIDTH +: WIDTH]
//   pwm_out    per-channel PWM outputs, registered
//   frame_tick one-cycle pulse in the first cycle of each frame
//   underrun   one-cycle pulse when a frame starts without a fresh sample
module pwm_audio_mc #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [WIDTH-1:0]        period,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [NUM_CH*WIDTH-1:0] s_data,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic                    frame_tick,
   output logic                    underrun
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0]        cnt, cnt_nxt;
   dir_t                    dir, dir_nxt;
   logic [WIDTH-1:0]        per_a;
   logic                    mode_a;
   logic [NUM_CH*WIDTH-1:0] duty;
   logic [NUM_CH*WIDTH-1:0] pend;
   logic                    pend_valid;
   logic                    wrap;
   logic                    take;
   logic [NUM_CH-1:0]       pwm_nxt;

   assign s_ready = !pend_valid;
   assign take    = s_valid && s_ready;

   // Counter next state. Edge mode ramps 0..per_a. Centre mode ramps up to
   // per_a and then back down to 1, so a frame has no repeated end values.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir;
      wrap    = 1'b0;
      if (!en) begin
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end else if (per_a == '0) begin
         wrap = 1'b1;
      end else if (!mode_a) begin
         if (cnt == per_a) wrap = 1'b1;
         else              cnt_nxt = cnt + ONE;
      end else if (dir == DIR_UP) begin
         if (cnt != per_a) begin
            cnt_nxt = cnt + ONE;
         end else if (per_a == ONE) begin
            // A two-count triangle has no room for a down leg.
            wrap = 1'b1;
         end else begin
            cnt_nxt = cnt - ONE;
            dir_nxt = DIR_DOWN;
         end
      end else begin
         if (cnt == ONE) wrap = 1'b1;
         else            cnt_nxt = cnt - ONE;
      end
      if (wrap) begin
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end
   end

   always_comb begin
      pwm_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pwm_nxt[i] = en && (cnt < duty[i*WIDTH +: WIDTH]);
      end
   end

   // NOTE: reset is synchronous here, so it only takes effect on a clock edge;
   // the duty and pending words are reset too, because a stale sample must
   // never reach the outputs after a reset.
   // NOTE: all state below uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         dir        <= DIR_UP;
         per_a      <= '0;
         mode_a     <= 1'b0;
         duty       <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         pwm_out    <= '0;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         dir        <= dir_nxt;
         pwm_out    <= pwm_nxt;
         frame_tick <= wrap;
         underrun   <= 1'b0;
         if (wrap) begin
            per_a  <= period;
            mode_a <= mode;
            if (pend_valid) begin
               duty       <= pend;
               pend_valid <= 1'b0;
            end else if (take) begin
               // A word arriving exactly on the boundary goes straight to the
               // active set instead of waiting a whole frame in the buffer.
               duty <= s_data;
            end else begin
               underrun <= 1'b1;
            end
         end else if (take) begin
            pend       <= s_data;
            pend_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_audio_mc.sv
// tb_pwm_audio_mc -- directed bench for pwm_audio_mc (WIDTH=8, NUM_CH=2).
//
// Accepted sample words go into a scoreboard queue; each frame start pops
// the next word (or expects an underrun when none is waiting). The bench then
// measures frame length and per-channel high time, and compares them against
// values computed from the period, mode and duty.
module tb_pwm_audio_mc;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        mode;
   logic [7:0]  period;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic [1:0]  pwm_out;
   logic        frame_tick;
   logic        underrun;

   pwm_audio_mc #(.WIDTH(8), .NUM_CH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .period     (period),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .pwm_out    (pwm_out),
      .frame_tick (frame_tick),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] feed_q[$];
   bit          auto_feed = 1'b0;
   logic [15:0] cur_duty = '0;
   logic [7:0]  cur_p = '0;
   logic        cur_m = 1'b0;
   logic [7:0]  edge_p = '0;
   logic        edge_m = 1'b0;

   function automatic logic [15:0] pack(input logic [7:0] c0, input logic [7:0] c1);
      return {c1, c0};
   endfunction

   function automatic int exp_len(input int p, input bit m);
      if (p == 0) return 1;
      return m ? 2 * p : p + 1;
   endfunction

   function automatic int exp_hi(input int d, input int p, input bit m);
      if (p == 0) return (d > 0) ? 1 : 0;
      if (!m)     return (d < p + 1) ? d : p + 1;
      if (d == 0) return 0;
      if (d > p)  return 2 * p;
      return 2 * d - 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive the feeder, record any handshake into the scoreboard,
   // and note the period/mode that a frame boundary on this edge latches.
   task automatic tick();
      logic        hs;
      logic [15:0] d;
      logic [7:0]  p_in;
      logic        m_in;
      logic [15:0] drop;
      if (auto_feed) begin
         s_valid = (feed_q.size() != 0);
         if (feed_q.size() != 0) s_data = feed_q[0];
      end
      hs   = s_valid && s_ready && rst_n;
      d    = s_data;
      p_in = period;
      m_in = mode;
      @(posedge clk);
      if (hs) begin
         exp_q.push_back(d);
         if (auto_feed) drop = feed_q.pop_front();
      end
      @(negedge clk);
      if (frame_tick === 1'b1) begin
         edge_p = p_in;
         edge_m = m_in;
      end
   endtask

   // Called in the first cycle of a frame (or the first cycle after a resume).
   // Runs to the next frame_tick counting cycles and high outputs; the output
   // seen on the closing cycle belongs to this frame because of the output
   // register.
   task automatic measure_frame(input string tag, input bit resumed,
                                input int change_at, input logic [7:0] new_p,
                                input logic new_m, input bit bypass,
                                input logic [15:0] bw);
      int len, h0, h1, el;
      len = 0; h0 = 0; h1 = 0;
      if (!resumed) begin
         chk({tag, "/tick"}, frame_tick, 1);
         chk({tag, "/underrun"}, underrun, exp_q.size() == 0);
         if (exp_q.size() != 0) cur_duty = exp_q.pop_front();
         cur_p = edge_p;
         cur_m = edge_m;
      end
      el = exp_len(int'(cur_p), cur_m);
      do begin
         if (len == change_at) begin
            period = new_p;
            mode   = new_m;
         end
         if (bypass && len == el - 1) begin
            s_valid = 1'b1;
            s_data  = bw;
         end
         tick();
         len++;
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
         if (len == 1 && el > 1) chk({tag, "/s_ready"}, s_ready, exp_q.size() == 0);
      end while (frame_tick !== 1'b1 && len < 600);
      if (bypass) s_valid = 1'b0;
      chk({tag, "/len"}, len, el);
      chk({tag, "/hi0"}, h0, exp_hi(int'(cur_duty[7:0]), int'(cur_p), cur_m));
      chk({tag, "/hi1"}, h1, exp_hi(int'(cur_duty[15:8]), int'(cur_p), cur_m));
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b0;
      mode    = 1'b0;
      period  = 8'd9;
      s_valid = 1'b0;
      s_data  = '0;

      // Reset state
      repeat (3) tick();
      chk("rst/pwm", pwm_out, 0);
      chk("rst/tick", frame_tick, 0);
      chk("rst/underrun", underrun, 0);
      chk("rst/s_ready", s_ready, 1);

      // Edge mode, P=9, ch0=3, ch1=10 (100 %)
      rst_n   = 1'b1;
      s_valid = 1'b1;
      s_data  = pack(8'd3, 8'd10);
      tick();
      s_valid = 1'b0;
      chk("load/s_ready", s_ready, 0);
      chk("load/pwm", pwm_out, 0);
      en = 1'b1;
      tick();
      measure_frame("edge1", 0, -1, 8'd0, 1'b0, 0, '0);

      // No new samples: underrun on every wrap, duty held
      measure_frame("ur1", 0, -1, 8'd0, 1'b0, 0, '0);
      measure_frame("ur2", 0, -1, 8'd0, 1'b0, 0, '0);

      // Period 9->3 mid-frame plus a handshake landing on the wrap edge
      measure_frame("bp_old", 0, 4, 8'd3, 1'b0, 1, pack(8'd1, 8'd2));
      measure_frame("bp_new", 0, -1, 8'd0, 1'b0, 0, '0);
      measure_frame("bp_ur", 0, -1, 8'd0, 1'b0, 0, '0);

      // s_valid held high: one word per frame, in order
      feed_q = '{pack(8'd0, 8'd5), pack(8'd4, 8'd2), pack(8'd1, 8'd4), pack(8'd3, 8'd3)};
      auto_feed = 1'b1;
      for (int i = 0; i < 5; i++) measure_frame($sformatf("feed%0d", i), 0, -1, 8'd0, 1'b0, 0, '0);
      auto_feed = 1'b0;

      // Centre mode, P=4
      feed_q = '{pack(8'd2, 8'd5), pack(8'd2, 8'd5), pack(8'd0, 8'd4), pack(8'd2, 8'd5)};
      auto_feed = 1'b1;
      measure_frame("ctr_sw", 0, 1, 8'd4, 1'b1, 0, '0);
      for (int i = 0; i < 4; i++) measure_frame($sformatf("ctr%0d", i), 0, -1, 8'd0, 1'b0, 0, '0);
      auto_feed = 1'b0;

      // Enable dropped mid-frame; handshake still fills the buffer
      repeat (3) tick();
      en      = 1'b0;
      s_valid = 1'b1;
      s_data  = pack(8'd3, 8'd1);
      tick();
      s_valid = 1'b0;
      chk("dis/pwm", pwm_out, 0);
      chk("dis/tick", frame_tick, 0);
      chk("dis/underrun", underrun, 0);
      tick();
      chk("dis/pwm2", pwm_out, 0);
      chk("dis/s_ready", s_ready, 0);
      en = 1'b1;
      measure_frame("resume", 1, -1, 8'd0, 1'b0, 0, '0);
      measure_frame("after_res", 0, -1, 8'd0, 1'b0, 0, '0);

      // Reset mid-frame drops the pending word
      s_valid = 1'b1;
      s_data  = pack(8'd7, 8'd7);
      tick();
      s_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      cur_duty = '0;
      chk("mrst/pwm", pwm_out, 0);
      chk("mrst/tick", frame_tick, 0);
      chk("mrst/underrun", underrun, 0);
      chk("mrst/s_ready", s_ready, 1);
      rst_n = 1'b1;
      tick();
      measure_frame("post_rst", 0, -1, 8'd0, 1'b0, 0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
